// File: rtl/pmem_line_adaptor.sv
// Turns one held 256-bit cache line read/write into a 4-beat 64-bit burst; minimum latency is
// accept + 1 request cycle + 4 beats + 1 resp cycle, beats stall on burst_resp=0, and the cache holds its request until pmem_resp.
module pmem_line_adaptor #(
    parameter int s_offset  = 5,
    parameter int s_line    = 256,
    parameter int s_burst   = 64,
    parameter int num_beats = s_line / s_burst
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pmem_address,
    input  logic               pmem_read,
    input  logic               pmem_write,
    input  logic [s_line-1:0]  pmem_wdata,
    output logic [s_line-1:0]  pmem_rdata,
    output logic               pmem_resp,
    output logic [31:0]        burst_address,
    output logic               burst_read,
    output logic               burst_write,
    output logic [s_burst-1:0] burst_wdata,
    input  logic [s_burst-1:0] burst_rdata,
    input  logic               burst_resp
);

    localparam int CW = (num_beats > 1) ? $clog2(num_beats) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [CW-1:0] LAST_BEAT = CW'(num_beats - 1);
    localparam logic [31:0]   ADDR_MASK = ~((32'd1 << s_offset) - 32'd1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      cnt_inc;
    logic [s_line-1:0]  line_q, line_d;
    logic [s_line-1:0]  rdata_q, rdata_d;
    logic               resp_q, resp_d;
    logic [31:0]        addr_q, addr_d;
    logic               bread_q, bread_d;
    logic               bwrite_q, bwrite_d;
    logic [s_burst-1:0] bwdata_q, bwdata_d;

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        line_d   = line_q;
        rdata_d  = rdata_q;
        resp_d   = 1'b0;
        addr_d   = addr_q;
        bread_d  = bread_q;
        bwrite_d = bwrite_q;
        bwdata_d = bwdata_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // Write takes priority when the cache raises both strobes.
                if (pmem_write) begin
                    state_d  = ST_WR;
                    addr_d   = pmem_address & ADDR_MASK;
                    line_d   = pmem_wdata;
                    bwrite_d = 1'b1;
                    bwdata_d = pmem_wdata[s_burst-1:0];
                end else if (pmem_read) begin
                    state_d = ST_RD;
                    addr_d  = pmem_address & ADDR_MASK;
                    bread_d = 1'b1;
                end
            end

            ST_RD: begin
                if (burst_resp) begin
                    bread_d = 1'b0;
                    rdata_d[cnt_q*s_burst +: s_burst] = burst_rdata;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                        resp_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            ST_WR: begin
                if (burst_resp) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d  = ST_DONE;
                        resp_d   = 1'b1;
                        bwrite_d = 1'b0;
                    end else begin
                        cnt_d    = cnt_inc;
                        bwdata_d = line_q[cnt_inc*s_burst +: s_burst];
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            line_q   <= '0;
            rdata_q  <= '0;
            resp_q   <= 1'b0;
            addr_q   <= '0;
            bread_q  <= 1'b0;
            bwrite_q <= 1'b0;
            bwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            line_q   <= line_d;
            rdata_q  <= rdata_d;
            resp_q   <= resp_d;
            addr_q   <= addr_d;
            bread_q  <= bread_d;
            bwrite_q <= bwrite_d;
            bwdata_q <= bwdata_d;
        end
    end

    assign pmem_rdata    = rdata_q;
    assign pmem_resp     = resp_q;
    assign burst_address = addr_q;
    assign burst_read    = bread_q;
    assign burst_write   = bwrite_q;
    assign burst_wdata   = bwdata_q;

endmodule

// File: tb/tb_pmem_line_adaptor.sv
// Directed bench for pmem_line_adaptor: inputs change and outputs are sampled on the falling edge.
module tb_pmem_line_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  burst_address;
    logic         burst_read;
    logic         burst_write;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_resp;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pmem_line_adaptor dut (
        .clk           (clk),
        .rst           (rst),
        .pmem_address  (pmem_address),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp),
        .burst_address (burst_address),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rdata"},  pmem_rdata, '0);
        chk({tag, ".resp"},   256'(pmem_resp), 256'd0);
        chk({tag, ".baddr"},  256'(burst_address), 256'd0);
        chk({tag, ".bread"},  256'(burst_read), 256'd0);
        chk({tag, ".bwrite"}, 256'(burst_write), 256'd0);
        chk({tag, ".bwdata"}, 256'(burst_wdata), 256'd0);
    endtask

    // Feeds four read beats with 'gap' idle cycles between them; burst_read must already be high.
    task automatic read_beats(input logic [255:0] ln, input int gap, input string tag);
        logic [255:0] l;
        l = ln;
        for (int i = 0; i < 4; i++) begin
            burst_resp  = 1'b1;
            burst_rdata = l[i*64 +: 64];
            @(negedge clk);
            burst_resp  = 1'b0;
            burst_rdata = 64'hdead_beef_dead_beef;
            if (i == 0) chk({tag, ".bread_drop"}, 256'(burst_read), 256'd0);
            if (i < 3) begin
                chk({tag, ".resp_early"}, 256'(pmem_resp), 256'd0);
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    chk({tag, ".resp_gap"}, 256'(pmem_resp), 256'd0);
                    chk({tag, ".bread_gap"}, 256'(burst_read), 256'd0);
                end
            end
        end
        chk({tag, ".resp"}, 256'(pmem_resp), 256'd1);
        chk({tag, ".rdata"}, pmem_rdata, ln);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_addr,
                           input logic [255:0] ln, input int gap, input string tag);
        pmem_address = addr;
        pmem_read    = 1'b1;
        @(negedge clk);
        chk({tag, ".bread"}, 256'(burst_read), 256'd1);
        chk({tag, ".baddr"}, 256'(burst_address), 256'(exp_addr));
        chk({tag, ".resp0"}, 256'(pmem_resp), 256'd0);
        pmem_address = 32'hffff_ffff;
        read_beats(ln, gap, tag);
        pmem_read = 1'b0;
        @(negedge clk);
        chk({tag, ".resp_pulse"}, 256'(pmem_resp), 256'd0);
        chk({tag, ".rdata_hold"}, pmem_rdata, ln);
    endtask

    // Write beats with burst_write assumed high and the first beat already on burst_wdata.
    task automatic write_beats(input logic [255:0] ln, input string tag);
        logic [255:0] l;
        l = ln;
        for (int i = 0; i < 4; i++) begin
            chk({tag, ".bwdata"}, 256'(burst_wdata), 256'(l[i*64 +: 64]));
            chk({tag, ".bwrite"}, 256'(burst_write), 256'd1);
            chk({tag, ".bread"}, 256'(burst_read), 256'd0);
            burst_resp = 1'b1;
            @(negedge clk);
            burst_resp = 1'b0;
            if (i < 3) chk({tag, ".resp_early"}, 256'(pmem_resp), 256'd0);
        end
        chk({tag, ".bwrite_drop"}, 256'(burst_write), 256'd0);
        chk({tag, ".resp"}, 256'(pmem_resp), 256'd1);
    endtask

    localparam logic [255:0] LINE_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] LINE_B = {64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210,
                                       64'ha5a5_a5a5_5a5a_5a5a, 64'h0f0f_0f0f_f0f0_f0f0};
    localparam logic [255:0] LINE_C = {64'hcafe_0000_0000_0004, 64'hcafe_0000_0000_0003,
                                       64'hcafe_0000_0000_0002, 64'hcafe_0000_0000_0001};
    localparam logic [255:0] LINE_D = {64'h8888_7777_6666_5555, 64'h1357_9bdf_2468_ace0,
                                       64'h0000_0000_ffff_ffff, 64'hffff_ffff_0000_0000};

    initial begin
        rst          = 1'b0;
        pmem_address = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wdata   = '0;
        burst_rdata  = '0;
        burst_resp   = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("idle");

        // T1: back-to-back read beats
        do_read(32'h0000_1040, 32'h0000_1040, LINE_A, 0, "t1");

        // T2: write; wdata scrambled after acceptance must not leak into beats
        pmem_address = 32'h8000_00e0;
        pmem_wdata   = LINE_A;
        pmem_write   = 1'b1;
        @(negedge clk);
        chk("t2.baddr", 256'(burst_address), 256'(32'h8000_00e0));
        pmem_wdata = LINE_B;
        write_beats(LINE_A, "t2");
        pmem_write = 1'b0;
        @(negedge clk);
        chk("t2.resp_pulse", 256'(pmem_resp), 256'd0);
        chk("t2.rdata_hold", pmem_rdata, LINE_A);

        // T3: two idle cycles between read beats
        do_read(32'h0000_2000, 32'h0000_2000, LINE_B, 2, "t3");

        // T4: unaligned address is line-aligned on the burst port
        do_read(32'h1234_567f, 32'h1234_5660, LINE_C, 0, "t4");

        // T5: reset mid-read after two beats
        pmem_address = 32'h0000_3000;
        pmem_read    = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            burst_resp  = 1'b1;
            burst_rdata = LINE_D[i*64 +: 64];
            @(negedge clk);
        end
        burst_resp = 1'b0;
        rst        = 1'b0;
        #1;
        chk_all_zero("t5.async");
        pmem_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5.no_resp", 256'(pmem_resp), 256'd0);
            chk("t5.no_bread", 256'(burst_read), 256'd0);
        end
        do_read(32'h0000_3000, 32'h0000_3000, LINE_D, 1, "t5");

        // T6: write wins over read, then the still-held read becomes a new request
        pmem_address = 32'h0000_4020;
        pmem_wdata   = LINE_C;
        pmem_read    = 1'b1;
        pmem_write   = 1'b1;
        @(negedge clk);
        chk("t6.baddr", 256'(burst_address), 256'(32'h0000_4020));
        write_beats(LINE_C, "t6");
        pmem_write   = 1'b0;
        pmem_address = 32'h0000_5000;
        begin
            int waited;
            waited = 0;
            while (burst_read !== 1'b1 && waited < 6) begin
                @(negedge clk);
                waited++;
                if (waited == 1) chk("t6.resp_pulse", 256'(pmem_resp), 256'd0);
            end
            chk("t6.reissue_delay", 256'(waited), 256'd2);
        end
        chk("t6.rd_baddr", 256'(burst_address), 256'(32'h0000_5000));
        read_beats(LINE_B, 0, "t6r");
        pmem_read = 1'b0;
        @(negedge clk);
        chk("t6r.resp_pulse", 256'(pmem_resp), 256'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
